seq_core: RTL and testbench
===========================

SEQ_CORE -- requirements
Module: seq_core

Interface
REQ-001 Parameter DW, 8, datapath/register/UART data width in bits (DW >= 2*RW).
REQ-002 Parameter NREG, 4, register-file entries (power of two, >= 2); RW = log2(NREG).
REQ-003 Parameter FIFO_DEPTH, 4, instruction-queue entries (power of two, >= 2).
REQ-004 Derived IW = 2 + RW + DW, instruction width; not user-set.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 i_inst  input  IW  instruction word.
REQ-008 i_inst_valid  input  1  i_inst offered this cycle.
REQ-009 o_inst_ready  output  1  queue can accept (not full).
REQ-010 o_tx_data  output  DW  byte/word to UART.
REQ-011 o_tx_valid  output  1  single-cycle transmit strobe.
REQ-012 i_tx_busy  input  1  UART transmitting.
REQ-013 o_busy  output  1  queue non-empty or FSM not IDLE.
REQ-014 o_fifo_cnt  output  log2(FIFO_DEPTH)+1  queue occupancy.

Function
REQ-015 Fields: op = inst[IW-1:IW-2]; ra = inst[IW-3:DW]; imm = inst[DW-1:0]; rb = inst[2*RW-1:RW]; rc = inst[RW-1:0].
REQ-016 Ops: 00 PUSH ra <= imm; 01 ADD rc <= ra+rb; 10 MULT rc <= low DW bits of ra*rb; 11 SEND transmit ra.
REQ-017 ADD/MULT wrap modulo 2^DW; carry and upper product bits discarded.
REQ-018 Enqueue when i_inst_valid & o_inst_ready; i_inst_valid while full is dropped, no state change.
REQ-019 Simultaneous enqueue and dequeue at any occupancy 1..FIFO_DEPTH-1 leaves o_fifo_cnt unchanged; when full, enqueue is refused even if a dequeue occurs that cycle.
REQ-020 Queue read/write pointers wrap modulo FIFO_DEPTH; order strictly FIFO.
REQ-021 FSM states IDLE, EXEC, TX_WAIT, TX_HOLD.
REQ-022 IDLE: if queue non-empty, dequeue head into instruction register, go EXEC; else stay.
REQ-023 EXEC, PUSH/ADD/MULT: register write at end of cycle, go IDLE; ALU op occupies exactly 2 cycles (dequeue to write).
REQ-024 EXEC, SEND: latch rf[ra] into o_tx_data, go TX_WAIT.
REQ-025 TX_WAIT: when i_tx_busy=0, assert o_tx_valid for exactly one cycle, go TX_HOLD; else stay with o_tx_valid=0.
REQ-026 TX_HOLD: one guard cycle, o_tx_valid=0, go IDLE.
REQ-027 o_tx_data stable from TX_WAIT entry through TX_HOLD.
REQ-028 Register reads use value after all prior instructions complete (no hazards; strictly sequential).
REQ-029 Writes to same register by back-to-back instructions: later value wins.

Reset
REQ-030 rst=0 at clock edge: FSM->IDLE, queue emptied, pointers 0, all registers 0.
REQ-031 Reset outputs: o_tx_valid=0, o_tx_data=0, o_inst_ready=1, o_busy=0, o_fifo_cnt=0.
REQ-032 Reset mid-send or mid-op aborts it; no o_tx_valid and no register write that cycle.

Configuration
REQ-033 Macro SEQ_MULT_EN defined: MULT per REQ-016.
REQ-034 Macro SEQ_MULT_EN undefined: op 10 is NOP, 2 cycles, no register write, no multiplier synthesised.

Verification
REQ-035 DW=8: PUSH r0,5; PUSH r1,7; ADD r0,r1->r2; SEND r2 -> one o_tx_valid pulse, o_tx_data=8'h0C.
REQ-036 PUSH r0,200; PUSH r1,100; ADD->r2; SEND r2 -> o_tx_data=8'h2C (wrap); with SEQ_MULT_EN PUSH 16,16 MULT, SEND -> 8'h00; without -> prior rc value sent.
REQ-037 Hold i_tx_busy=1 10 cycles during SEND -> o_tx_valid=0 throughout, single pulse first cycle after busy falls.
REQ-038 Stall on send, offer 6 instructions, FIFO_DEPTH=4 -> 4 accepted, o_inst_ready=0, excess dropped, o_fifo_cnt=4.
REQ-039 Assert rst in TX_WAIT -> no o_tx_valid, o_fifo_cnt=0, subsequent SEND of any register -> data 0.
REQ-040 Continuous valid stream of PUSHes -> o_fifo_cnt bounded, every PUSH retired in order, o_busy falls 2 cycles after last dequeue.

Source files
------------

// File: rtl/seq_core.sv
// seq_core: small sequential instruction engine.
//
// Instructions enter through a FIFO queue. A four-state FSM takes them out
// one at a time and executes them against a register file. Results can be
// sent to a UART.
//
// Instruction word layout, IW = 2 + RW + DW bits:
//   [IW-1:IW-2] op   00 PUSH  ra <= imm
//                    01 ADD   rc <= ra + rb      (wraps mod 2^DW)
//                    10 MULT  rc <= low DW bits of ra * rb
//                    11 SEND  transmit ra
//   [IW-3:DW]   ra
//   [DW-1:0]    imm, which also holds rb = imm[2*RW-1:RW] and rc = imm[RW-1:0]
//
// Build option:
//   SEQ_MULT_EN  When defined, MULT is implemented. When undefined, op 10
//                still takes 2 cycles but writes nothing, and no multiplier
//                is built.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active low
//   i_inst        instruction word
//   i_inst_valid  i_inst is offered this cycle (dropped while the queue is full)
//   o_inst_ready  queue is not full
//   o_tx_data     word to the UART; holds its value from TX_WAIT through TX_HOLD
//   o_tx_valid    one-cycle transmit strobe
//   i_tx_busy     UART is transmitting
//   o_busy        queue is non-empty or the FSM is not in IDLE
//   o_fifo_cnt    queue occupancy
module seq_core #(
  parameter  int DW         = 8,
  parameter  int NREG       = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int RW         = $clog2(NREG),
  localparam int IW         = 2 + RW + DW,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] i_inst,
  input  logic          i_inst_valid,
  output logic          o_inst_ready,
  output logic [DW-1:0] o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_busy,
  output logic          o_busy,
  output logic [AW:0]   o_fifo_cnt
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, TX_WAIT, TX_HOLD} state_e;

  typedef struct packed {
    logic [1:0]    op;
    logic [RW-1:0] ra;
    logic [DW-1:0] imm;
  } inst_t;

  // ---------------- instruction queue ----------------
  inst_t           fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            full, empty, push, pop;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  // The accept decision uses only "full". A dequeue in the same cycle does
  // not open a slot for the incoming word.
  assign push  = i_inst_valid & ~full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= i_inst;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- register file / datapath ----------------
  logic [NREG-1:0][DW-1:0] rf;
  inst_t                   ir;
  logic [RW-1:0]           rb, rc;
  logic [DW-1:0]           opa, opb;
  logic                    rf_we;
  logic [RW-1:0]           rf_wa;
  logic [DW-1:0]           rf_wd;
  logic                    tx_ld;

  assign rb  = ir.imm[2*RW-1:RW];
  assign rc  = ir.imm[RW-1:0];
  assign opa = rf[ir.ra];
  assign opb = rf[rb];

`ifdef SEQ_MULT_EN
  logic [DW-1:0] mul_res;
  // The result is sized to DW, so only the low half of the product is kept.
  assign mul_res = opa * opb;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf        <= '0;
      ir        <= '0;
      o_tx_data <= '0;
    end else begin
      if (pop)   ir         <= fifo_mem[rd_ptr];
      if (rf_we) rf[rf_wa]  <= rf_wd;
      if (tx_ld) o_tx_data  <= opa;
    end
  end

  // ---------------- control FSM ----------------
  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = ir.ra;
    rf_wd      = ir.imm;
    tx_ld      = 1'b0;
    o_tx_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        case (ir.op)
          OP_PUSH: rf_we = 1'b1;
          OP_ADD: begin
            rf_we = 1'b1;
            rf_wa = rc;
            rf_wd = opa + opb;
          end
          OP_MULT: begin
`ifdef SEQ_MULT_EN
            rf_we = 1'b1;
            rf_wa = rc;
            rf_wd = mul_res;
`endif
          end
          OP_SEND: begin
            tx_ld   = 1'b1;
            state_d = TX_WAIT;
          end
          default: ;
        endcase
      end
      TX_WAIT: begin
        if (!i_tx_busy) begin
          // A reset in this cycle cancels the strobe.
          o_tx_valid = rst;
          state_d    = TX_HOLD;
        end
      end
      TX_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_inst_ready = ~full;
  assign o_busy       = ~empty | (state_q != IDLE);
  assign o_fifo_cnt   = cnt;

endmodule

// File: tb/tb_seq_core.sv
module tb_seq_core;
  localparam int DW = 8;
  localparam int NREG = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int IW = 2 + 2 + DW;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

`ifdef SEQ_MULT_EN
  localparam logic [7:0] E_MUL1 = 8'h00;
  localparam logic [7:0] E_DBL  = 8'h00;
  localparam logic [7:0] E_MUL2 = 8'hE0;
`else
  localparam logic [7:0] E_MUL1 = 8'h2C;
  localparam logic [7:0] E_DBL  = 8'h58;
  localparam logic [7:0] E_MUL2 = 8'h10;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] i_inst;
  logic          i_inst_valid;
  logic          o_inst_ready;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_busy;
  logic          o_busy;
  logic [2:0]    o_fifo_cnt;

  seq_core #(.DW(DW), .NREG(NREG), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .i_inst(i_inst), .i_inst_valid(i_inst_valid),
    .o_inst_ready(o_inst_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_busy(i_tx_busy), .o_busy(o_busy), .o_fifo_cnt(o_fifo_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  typedef struct {
    logic [1:0] op;
    logic [1:0] ra;
    logic [7:0] imm;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [1:0] op, input logic [1:0] ra,
                                       input logic [7:0] imm);
    return {op, ra, imm};
  endfunction

  // Every transmit strobe is compared against the oldest expected word.
  always @(negedge clk) begin
    if (o_tx_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got 0x%0h want no strobe", o_tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_data", 32'(o_tx_data), 32'(mon_e));
      end
    end
  end

  task automatic push_inst(input logic [IW-1:0] w);
    int n = 0;
    @(negedge clk);
    while (!o_inst_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got ready=0 want ready=1");
    end
    i_inst = w;
    i_inst_valid = 1'b1;
    @(posedge clk);
    #1 i_inst_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((o_busy || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d want 0/0", o_busy, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, idx, n;
    logic rdy;

    rst = 1'b0; i_inst = '0; i_inst_valid = 1'b0; i_tx_busy = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(o_tx_valid), 0);
    chk("rst_tx_data", 32'(o_tx_data), 0);
    chk("rst_ready", 32'(o_inst_ready), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_cnt", 32'(o_fifo_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // table-driven program. rb/rc are packed into imm as {4'b0, rb, rc}.
    tbl[0]  = '{OP_PUSH, 2'd0, 8'd5,   8'h00};
    tbl[1]  = '{OP_PUSH, 2'd1, 8'd7,   8'h00};
    tbl[2]  = '{OP_ADD,  2'd0, 8'h06,  8'h00};
    tbl[3]  = '{OP_SEND, 2'd2, 8'h00,  8'h0C};
    tbl[4]  = '{OP_PUSH, 2'd0, 8'd200, 8'h00};
    tbl[5]  = '{OP_PUSH, 2'd1, 8'd100, 8'h00};
    tbl[6]  = '{OP_ADD,  2'd0, 8'h06,  8'h00};
    tbl[7]  = '{OP_SEND, 2'd2, 8'h00,  8'h2C};
    tbl[8]  = '{OP_PUSH, 2'd0, 8'd16,  8'h00};
    tbl[9]  = '{OP_PUSH, 2'd1, 8'd16,  8'h00};
    tbl[10] = '{OP_MULT, 2'd0, 8'h06,  8'h00};
    tbl[11] = '{OP_SEND, 2'd2, 8'h00,  E_MUL1};
    tbl[12] = '{OP_ADD,  2'd2, 8'h0B,  8'h00};
    tbl[13] = '{OP_SEND, 2'd3, 8'h00,  E_DBL};
    tbl[14] = '{OP_PUSH, 2'd3, 8'hFF,  8'h00};
    tbl[15] = '{OP_ADD,  2'd3, 8'h0F,  8'h00};
    tbl[16] = '{OP_SEND, 2'd3, 8'h00,  8'hFE};
    tbl[17] = '{OP_MULT, 2'd3, 8'h04,  8'h00};
    tbl[18] = '{OP_SEND, 2'd0, 8'h00,  E_MUL2};
    tbl[19] = '{OP_SEND, 2'd1, 8'h00,  8'h10};
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].op == OP_SEND) exp_q.push_back(tbl[i].exp);
      push_inst(mk(tbl[i].op, tbl[i].ra, tbl[i].imm));
    end
    wait_idle();

    // UART busy for 10 cycles while a SEND is waiting
    i_tx_busy = 1'b1;
    exp_q.push_back(8'h10);
    push_inst(mk(OP_SEND, 2'd1, 8'h00));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_no_valid", 32'(o_tx_valid), 0);
      chk("hold_data", 32'(o_tx_data), 32'h10);
    end
    @(posedge clk);
    #1 i_tx_busy = 1'b0;
    p0 = pulses;
    @(negedge clk);
    chk("pulse_first_cycle", 32'(o_tx_valid), 1);
    @(negedge clk);
    chk("guard_no_valid", 32'(o_tx_valid), 0);
    chk("guard_data_stable", 32'(o_tx_data), 32'h10);
    repeat (3) @(negedge clk);
    chk("single_pulse", 32'(pulses - p0), 1);
    wait_idle();

    // stall on a SEND and offer 6 instructions to a 4-deep queue
    i_tx_busy = 1'b1;
    exp_q.push_back(8'h33);
    push_inst(mk(OP_PUSH, 2'd0, 8'h33));
    push_inst(mk(OP_SEND, 2'd0, 8'h00));
    repeat (4) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("full_ready", 32'(o_inst_ready), (k < 4) ? 32'd1 : 32'd0);
      i_inst = mk(OP_PUSH, 2'd0, 8'(k + 1));
      i_inst_valid = 1'b1;
    end
    @(negedge clk);
    i_inst_valid = 1'b0;
    chk("full_cnt", 32'(o_fifo_cnt), 4);
    chk("full_not_ready", 32'(o_inst_ready), 0);
    @(posedge clk);
    #1 i_tx_busy = 1'b0;
    exp_q.push_back(8'h04);
    push_inst(mk(OP_SEND, 2'd0, 8'h00));
    wait_idle();

    // reset while in TX_WAIT: no strobe, queue flushed, registers cleared
    i_tx_busy = 1'b1;
    push_inst(mk(OP_PUSH, 2'd2, 8'h77));
    push_inst(mk(OP_SEND, 2'd2, 8'h00));
    push_inst(mk(OP_PUSH, 2'd1, 8'h55));
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(o_busy), 1);
    chk("pre_rst_cnt", 32'(o_fifo_cnt), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_tx_busy = 1'b0;
    @(negedge clk);
    chk("rst_abort_valid", 32'(o_tx_valid), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cnt", 32'(o_fifo_cnt), 0);
    chk("post_rst_busy", 32'(o_busy), 0);
    chk("post_rst_data", 32'(o_tx_data), 0);
    exp_q.push_back(8'h00);
    push_inst(mk(OP_SEND, 2'd2, 8'h00));
    exp_q.push_back(8'h00);
    push_inst(mk(OP_SEND, 2'd1, 8'h00));
    wait_idle();

    // continuous PUSH stream, 10 words into r(k%4) = k+1
    idx = 0;
    n = 0;
    while (idx < 10 && n < 200) begin
      @(negedge clk);
      chk("stream_cnt_bound", 32'(o_fifo_cnt <= 3'(FIFO_DEPTH)), 1);
      i_inst = mk(OP_PUSH, 2'(idx % 4), 8'(idx + 1));
      i_inst_valid = 1'b1;
      rdy = o_inst_ready;
      @(posedge clk);
      if (rdy) idx++;
      n++;
    end
    #1 i_inst_valid = 1'b0;
    chk("stream_all_accepted", 32'(idx), 10);
    n = 0;
    @(negedge clk);
    while (o_fifo_cnt != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stream_drained", 32'(o_fifo_cnt), 0);
    chk("busy_after_last_deq", 32'(o_busy), 1);
    @(negedge clk);
    chk("busy_falls", 32'(o_busy), 0);
    exp_q.push_back(8'd9);
    push_inst(mk(OP_SEND, 2'd0, 8'h00));
    exp_q.push_back(8'd10);
    push_inst(mk(OP_SEND, 2'd1, 8'h00));
    exp_q.push_back(8'd7);
    push_inst(mk(OP_SEND, 2'd2, 8'h00));
    exp_q.push_back(8'd8);
    push_inst(mk(OP_SEND, 2'd3, 8'h00));
    wait_idle();

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
